// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: synchronises the rows, scans the columns, debounces
// single-key presses and queues their 4-bit codes for the MMIO Keypad word.
module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        data_clk,
   input  logic        rst,
   input  logic [3:0]  kp_row,
   output logic [3:0]  kp_col,
   input  logic        pop,
   input  logic        clr,
   output logic [31:0] key_word,
   output logic        key_pressed
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit ONE_SCAN = (DEBOUNCE_SCANS == 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_CAND, S_HELD, S_REL} state_t;

   function automatic logic [3:0] key_code(input logic [3:0] idx);
      logic [3:0] c;
      case (idx)
         4'd0:  c = 4'h1;  4'd1:  c = 4'h2;  4'd2:  c = 4'h3;  4'd3:  c = 4'hA;
         4'd4:  c = 4'h4;  4'd5:  c = 4'h5;  4'd6:  c = 4'h6;  4'd7:  c = 4'hB;
         4'd8:  c = 4'h7;  4'd9:  c = 4'h8;  4'd10: c = 4'h9;  4'd11: c = 4'hC;
         4'd12: c = 4'hE;  4'd13: c = 4'h0;  4'd14: c = 4'hF;  default: c = 4'hD;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] onehot_idx(input logic [15:0] v);
      logic [3:0] i;
      i = '0;
      for (int k = 0; k < 16; k++)
         if (v[k]) i = 4'(k);
      return i;
   endfunction

   logic [3:0]       row_p0, row_p1;
   logic [3:0]       rows;
   logic [DIV_W-1:0] div;
   logic [1:0]       col;
   logic [15:0]      raw;
   logic             scan_end;

   state_t           state, state_nx;
   logic [3:0]       cand, cand_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
   logic             cnt_done, raw_onehot, cand_on, cand_only;
   logic             push, key_pressed_nx;
   logic [3:0]       push_code;

   logic [3:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [3:0]       count;
   logic             overflow, fifo_empty, fifo_full, do_push, do_pop;
   logic [3:0]       head_code;
   logic [2:0]       count_field;

   // Stage p0/p1: two-flop row synchroniser; rows idle high so reset to all ones
   always_ff @(posedge data_clk or posedge rst) begin
      if (rst) begin
         row_p0 <= 4'hF;
         row_p1 <= 4'hF;
      end else begin
         row_p0 <= kp_row;
         row_p1 <= row_p0;
      end
   end

   assign rows = ~row_p1;

   // Column scan: latch the driven column at terminal count, strobe after column 3
   always_ff @(posedge data_clk or posedge rst) begin
      if (rst) begin
         div      <= '0;
         col      <= 2'd0;
         raw      <= '0;
         scan_end <= 1'b0;
      end else begin
         scan_end <= 1'b0;
         if (div == DIV_LAST) begin
            div <= '0;
            for (int r = 0; r < 4; r++)
               raw[r*4 + int'(col)] <= rows[r];
            col      <= col + 2'd1;
            scan_end <= (col == 2'd3);
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   assign kp_col = ~(4'b0001 << col);

   assign raw_onehot = (raw != 16'd0) && ((raw & (raw - 16'd1)) == 16'd0);
   assign cand_on    = raw[cand];
   assign cand_only  = (raw == (16'd1 << cand));
   assign cnt_inc    = cnt + CNT_ONE;
   assign cnt_done   = (cnt_inc == CNT_LAST);

   always_ff @(posedge data_clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cand        <= 4'd0;
         cnt         <= '0;
         key_pressed <= 1'b0;
      end else begin
         state       <= state_nx;
         cand        <= cand_nx;
         cnt         <= cnt_nx;
         key_pressed <= key_pressed_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      cnt_nx   = cnt;
      if (scan_end) begin
         case (state)
            S_IDLE: if (raw_onehot) begin
               cand_nx  = onehot_idx(raw);
               cnt_nx   = CNT_ONE;
               state_nx = ONE_SCAN ? S_HELD : S_CAND;
            end
            S_CAND: if (cand_only) begin
               cnt_nx = cnt_inc;
               if (cnt_done) state_nx = S_HELD;
            end else begin
               state_nx = S_IDLE;
            end
            S_HELD: if (!cand_on) begin
               cnt_nx   = CNT_ONE;
               state_nx = ONE_SCAN ? S_IDLE : S_REL;
            end
            default: if (cand_on) begin
               state_nx = S_HELD;
            end else begin
               cnt_nx = cnt_inc;
               if (cnt_done) state_nx = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      push = scan_end && (((state == S_IDLE) && raw_onehot && ONE_SCAN) ||
                          ((state == S_CAND) && cand_only && cnt_done));
      push_code      = key_code(cand_nx);
      key_pressed_nx = (state_nx == S_HELD) || (state_nx == S_REL);
   end

   // FIFO: decisions taken against the pre-cycle occupancy
   assign fifo_empty = (count == 4'd0);
   assign fifo_full  = (count == DEPTH_C);
   assign do_pop     = pop && !fifo_empty;
   assign do_push    = push && (!fifo_full || do_pop);

   always_ff @(posedge data_clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= 4'd0;
         overflow <= 1'b0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= 4'd0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge data_clk) begin
      if (do_push && !clr) mem[wr_ptr] <= push_code;
   end

   assign head_code   = fifo_empty ? 4'h0 : mem[rd_ptr];
   assign count_field = (count > 4'd7) ? 3'd7 : count[2:0];
   assign key_word    = {!fifo_empty, overflow, 19'b0, count_field, 4'b0, head_code};

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the column
// drive, and a scoreboard queue of expected codes models the key FIFO.
module tb_keypad_scanner;

   logic        data_clk = 1'b0;
   logic        rst, pop, clr;
   logic [3:0]  kp_row, kp_col;
   logic [31:0] key_word;
   logic        key_pressed;
   logic [15:0] pressed;

   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  exp_q [$];
   logic        exp_ovf;

   always #5 data_clk = ~data_clk;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)) dut (
      .data_clk(data_clk), .rst(rst), .kp_row(kp_row), .kp_col(kp_col),
      .pop(pop), .clr(clr), .key_word(key_word), .key_pressed(key_pressed)
   );

   always_comb begin
      kp_row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4 + c] && !kp_col[c]) kp_row[r] = 1'b0;
   end

   function automatic logic [3:0] code_of(input int idx);
      logic [3:0] t [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
      return t[idx];
   endfunction

   function automatic logic [31:0] exp_word();
      int n;
      logic [3:0] h;
      n = exp_q.size();
      h = (n != 0) ? exp_q[0] : 4'h0;
      return {(n != 0), exp_ovf, 19'b0, 3'(n), 4'b0, h};
   endfunction

   task automatic sb_push(input int idx);
      if (exp_q.size() < 4) exp_q.push_back(code_of(idx));
      else exp_ovf = 1'b1;
   endtask

   task automatic wait_scans(input int n);
      repeat (n * 16) @(negedge data_clk);
   endtask

   task automatic do_pop();
      pop = 1'b1;
      @(negedge data_clk);
      pop = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge data_clk);
      clr = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   // Returns at the negedge of the cycle in which the scan-end strobe is high.
   task automatic wait_scan_start();
      int n = 0;
      while (kp_col == 4'b1110 && n < 64) begin @(negedge data_clk); n++; end
      while (kp_col != 4'b1110 && n < 64) begin @(negedge data_clk); n++; end
      if (n >= 64) begin
         n_vec++; n_err++;
         $display("FAIL scan_sync: no scan boundary within %0d cycles, kp_col=%b", n, kp_col);
      end
   endtask

   task automatic test_reset();
      logic [3:0] e;
      rst = 1'b1; pop = 1'b0; clr = 1'b0; pressed = '0;
      exp_q.delete(); exp_ovf = 1'b0;
      repeat (3) @(negedge data_clk);
      rst = 1'b0;
      n_vec++;
      if (key_word !== 32'h0) begin
         n_err++; $display("FAIL reset_word: got %h want %h", key_word, 32'h0);
      end
      n_vec++;
      if (key_pressed !== 1'b0) begin
         n_err++; $display("FAIL reset_pressed: got %b want 0", key_pressed);
      end
      for (int i = 0; i < 4; i++) begin
         e = ~(4'b0001 << i);
         n_vec++;
         if (kp_col !== e) begin
            n_err++; $display("FAIL col_walk%0d: got %b want %b", i, kp_col, e);
         end
         repeat (4) @(negedge data_clk);
      end
   endtask

   task automatic test_reset_mid_press();
      pressed[4] = 1'b1;
      repeat (24) @(negedge data_clk);
      rst = 1'b1;
      pressed = '0;
      @(negedge data_clk);
      n_vec++;
      if (kp_col !== 4'b1110) begin
         n_err++; $display("FAIL midrst_col: got %b want 1110", kp_col);
      end
      @(negedge data_clk);
      rst = 1'b0;
      wait_scans(4);
      n_vec++;
      if (key_word !== exp_word() || key_pressed !== 1'b0) begin
         n_err++; $display("FAIL midrst_word: got %h/%b want %h/0", key_word, key_pressed, exp_word());
      end
   endtask

   task automatic test_single_press();
      pressed[5] = 1'b1;
      wait_scans(6);
      sb_push(5);
      n_vec++;
      if (key_word !== exp_word() || key_word !== 32'h8000_0105) begin
         n_err++; $display("FAIL press5_word: got %h want %h", key_word, 32'h8000_0105);
      end
      n_vec++;
      if (key_pressed !== 1'b1) begin
         n_err++; $display("FAIL press5_held: got %b want 1", key_pressed);
      end
      pressed = '0;
      wait_scans(3);
      n_vec++;
      if (key_pressed !== 1'b0 || key_word !== exp_word()) begin
         n_err++; $display("FAIL release5: got %h/%b want %h/0", key_word, key_pressed, exp_word());
      end
      n_vec++;
      if (key_word[3:0] !== exp_q[0]) begin
         n_err++; $display("FAIL pop5_head: got %h want %h", key_word[3:0], exp_q[0]);
      end
      do_pop();
      n_vec++;
      if (key_word !== exp_word()) begin
         n_err++; $display("FAIL pop5_empty: got %h want %h", key_word, exp_word());
      end
   endtask

   task automatic test_bounce();
      pressed[10] = 1'b1;
      repeat (12) @(negedge data_clk);
      pressed = '0;
      wait_scans(4);
      n_vec++;
      if (key_word !== exp_word() || key_pressed !== 1'b0) begin
         n_err++; $display("FAIL bounce9: got %h/%b want %h/0", key_word, key_pressed, exp_word());
      end
      pressed[10] = 1'b1;
      wait_scans(5);
      sb_push(10);
      pressed = '0;
      repeat (12) @(negedge data_clk);
      pressed[10] = 1'b1;
      wait_scans(3);
      n_vec++;
      if (key_word !== exp_word() || key_pressed !== 1'b1) begin
         n_err++; $display("FAIL rebounce9: got %h/%b want %h/1", key_word, key_pressed, exp_word());
      end
      pressed = '0;
      wait_scans(4);
      n_vec++;
      if (key_word !== 32'h8000_0109 || key_pressed !== 1'b0) begin
         n_err++; $display("FAIL release9: got %h/%b want %h/0", key_word, key_pressed, 32'h8000_0109);
      end
      do_pop();
   endtask

   task automatic test_ghost();
      pressed[0] = 1'b1; pressed[1] = 1'b1;
      wait_scans(4);
      n_vec++;
      if (key_word !== exp_word() || key_pressed !== 1'b0) begin
         n_err++; $display("FAIL ghost12: got %h/%b want %h/0", key_word, key_pressed, exp_word());
      end
      pressed = '0;
      wait_scans(3);
   endtask

   task automatic test_overflow();
      int keys [5] = '{0, 1, 2, 3, 7};
      foreach (keys[k]) begin
         pressed[keys[k]] = 1'b1;
         wait_scans(4);
         sb_push(keys[k]);
         pressed = '0;
         wait_scans(4);
         n_vec++;
         if (key_word !== exp_word()) begin
            n_err++; $display("FAIL seq_key%0d: got %h want %h", k, key_word, exp_word());
         end
      end
      n_vec++;
      if (key_word !== 32'hC000_0401) begin
         n_err++; $display("FAIL overflow_word: got %h want %h", key_word, 32'hC000_0401);
      end
      n_vec++;
      if (key_word[3:0] !== exp_q[0]) begin
         n_err++; $display("FAIL ovf_pop_head: got %h want %h", key_word[3:0], exp_q[0]);
      end
      do_pop();
      n_vec++;
      if (key_word !== exp_word() || key_word !== 32'hC000_0302) begin
         n_err++; $display("FAIL ovf_after_pop: got %h want %h", key_word, 32'hC000_0302);
      end
      do_clr();
      n_vec++;
      if (key_word !== exp_word()) begin
         n_err++; $display("FAIL clr_word: got %h want %h", key_word, exp_word());
      end
   endtask

   task automatic test_push_pop_same_cycle();
      int keys [2] = '{8, 9};
      foreach (keys[k]) begin
         pressed[keys[k]] = 1'b1;
         wait_scans(4);
         sb_push(keys[k]);
         pressed = '0;
         wait_scans(4);
      end
      n_vec++;
      if (key_word !== exp_word() || key_word !== 32'h8000_0207) begin
         n_err++; $display("FAIL two_queued: got %h want %h", key_word, 32'h8000_0207);
      end
      wait_scan_start();
      pressed[14] = 1'b1;
      wait_scan_start();
      wait_scan_start();
      pop = 1'b1;
      n_vec++;
      if (key_word[3:0] !== exp_q[0]) begin
         n_err++; $display("FAIL pp_head: got %h want %h", key_word[3:0], exp_q[0]);
      end
      void'(exp_q.pop_front());
      sb_push(14);
      @(negedge data_clk);
      pop = 1'b0;
      n_vec++;
      if (key_word !== exp_word() || key_word[31:8] !== 24'h8000_02) begin
         n_err++; $display("FAIL push_pop: got %h want %h", key_word, exp_word());
      end
      pressed = '0;
      wait_scans(4);
      for (int i = 0; i < 3; i++) begin
         do_pop();
         n_vec++;
         if (key_word !== exp_word()) begin
            n_err++; $display("FAIL drain%0d: got %h want %h", i, key_word, exp_word());
         end
      end
      n_vec++;
      if (key_word !== 32'h0) begin
         n_err++; $display("FAIL empty_pop: got %h want %h", key_word, 32'h0);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_press();
      test_single_press();
      test_bounce();
      test_ghost();
      test_overflow();
      test_push_pop_same_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
